// File: rtl/add_and_div.sv
// Sequential signed divider computing (inA + inC) / inB, one restoring iteration per clock.
// Optional build macro ADD_AND_DIV_FAST_ZERO_EN: a zero divisor skips CALC and goes straight to FIX.
module add_and_div #(
   parameter int unsigned n = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [n-1:0] inA,
   input  logic [n-1:0] inC,
   input  logic [n-1:0] inB,
   input  logic         start,
   output logic [n-1:0] result,
   output logic [n-1:0] remainder,
   output logic         overflow,
   output logic         ready
);

`ifdef ADD_AND_DIV_FAST_ZERO_EN
   localparam bit FastZero = 1'b1;
`else
   localparam bit FastZero = 1'b0;
`endif

   localparam int unsigned CntW = $clog2(n + 2);
   localparam logic [CntW-1:0] CntLoad = CntW'(n + 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   typedef enum logic [1:0] {
      StIdle,
      StCalc,
      StFix
   } state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   // Dividend magnitude shifts out of the top while quotient bits shift in at the bottom.
   logic [n:0]      quo_q, quo_d;
   logic [n-1:0]    rem_q, rem_d;
   logic [n-1:0]    div_q, div_d;
   logic            neg_quo_q, neg_quo_d;
   logic            neg_rem_q, neg_rem_d;
   logic            div_zero_q, div_zero_d;
   logic [n-1:0]    result_q, result_d;
   logic [n-1:0]    remainder_q, remainder_d;
   logic            overflow_q, overflow_d;

   logic [n:0]      sum;
   logic [n:0]      sum_mag;
   logic [n-1:0]    b_mag;
   logic            b_zero;
   logic [n:0]      rem_shift;
   logic            trial_ok;
   logic [n+1:0]    quo_ext;
   logic [n+1:0]    quo_sgn;
   logic [n-1:0]    rem_sgn;
   logic            quo_range_ok;

   // Operand preparation: the sum is formed at n+1 bits so it never wraps.
   always_comb begin
      sum     = {inA[n-1], inA} + {inC[n-1], inC};
      sum_mag = sum[n] ? -sum : sum;
      b_mag   = inB[n-1] ? -inB : inB;
      b_zero  = (inB == '0);
   end

   // One restoring-division step: shift in a dividend bit, trial-subtract, keep or restore.
   always_comb begin
      rem_shift = {rem_q, quo_q[n]};
      trial_ok  = (rem_shift >= {1'b0, div_q});
   end

   // Sign correction; the quotient needs n+2 bits to hold +2^n and detect overflow.
   always_comb begin
      quo_ext      = {1'b0, quo_q};
      quo_sgn      = neg_quo_q ? -quo_ext : quo_ext;
      rem_sgn      = neg_rem_q ? -rem_q : rem_q;
      quo_range_ok = (quo_sgn[n+1:n-1] == '0) || (quo_sgn[n+1:n-1] == '1);
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      quo_d       = quo_q;
      rem_d       = rem_q;
      div_d       = div_q;
      neg_quo_d   = neg_quo_q;
      neg_rem_d   = neg_rem_q;
      div_zero_d  = div_zero_q;
      result_d    = result_q;
      remainder_d = remainder_q;
      overflow_d  = overflow_q;

      case (state_q)
         StIdle: begin
            if (start) begin
               quo_d      = sum_mag;
               rem_d      = '0;
               div_d      = b_mag;
               neg_quo_d  = sum[n] ^ inB[n-1];
               neg_rem_d  = sum[n];
               div_zero_d = b_zero;
               cnt_d      = CntLoad;
               state_d    = (FastZero && b_zero) ? StFix : StCalc;
            end
         end

         StCalc: begin
            if (trial_ok) begin
               rem_d = n'(rem_shift - {1'b0, div_q});
               quo_d = {quo_q[n-1:0], 1'b1};
            end else begin
               rem_d = rem_shift[n-1:0];
               quo_d = {quo_q[n-1:0], 1'b0};
            end
            cnt_d = cnt_q - CntOne;
            if (cnt_q == CntOne) begin
               state_d = StFix;
            end
         end

         StFix: begin
            if (div_zero_q) begin
               result_d    = '0;
               remainder_d = '0;
               overflow_d  = 1'b1;
            end else begin
               result_d    = quo_sgn[n-1:0];
               remainder_d = rem_sgn;
               overflow_d  = !quo_range_ok;
            end
            cnt_d   = '0;
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         div_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         div_zero_q  <= 1'b0;
         result_q    <= '0;
         remainder_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         quo_q       <= quo_d;
         rem_q       <= rem_d;
         div_q       <= div_d;
         neg_quo_q   <= neg_quo_d;
         neg_rem_q   <= neg_rem_d;
         div_zero_q  <= div_zero_d;
         result_q    <= result_d;
         remainder_q <= remainder_d;
         overflow_q  <= overflow_d;
      end
   end

   assign result    = result_q;
   assign remainder = remainder_q;
   assign overflow  = overflow_q;
   assign ready     = (state_q == StIdle);

endmodule

// File: tb/tb_add_and_div.sv
// Scoreboard bench for add_and_div: stimulus pushes hand-computed expectations, a negedge
// monitor pops and compares them whenever ready rises after a completed operation.
module tb_add_and_div;

   localparam int Lat = 34;
`ifdef ADD_AND_DIV_FAST_ZERO_EN
   localparam int ZeroLat = 1;
`else
   localparam int ZeroLat = 34;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] inA, inC, inB;
   logic        start;
   logic [31:0] result, remainder;
   logic        overflow, ready;

   typedef struct {
      logic [31:0] res;
      logic [31:0] rem;
      logic        ov;
      int          done;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic ready_prev = 1'b1;
   logic rst_seen = 1'b1;
   exp_t e;

   add_and_div #(.n(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .inA       (inA),
      .inC       (inC),
      .inB       (inB),
      .start     (start),
      .result    (result),
      .remainder (remainder),
      .overflow  (overflow),
      .ready     (ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= !rst_n;
   end

   task automatic chk(input string name, input int id, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s op%0d: got %h expected %h (cycle %0d)", name, id, act, exp, cyc);
      end
   endtask

   // Monitor: a rise of ready not caused by reset marks a completed operation.
   always @(negedge clk) begin
      if (ready === 1'b1 && ready_prev !== 1'b1 && !rst_seen) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion: got result %h expected no completion", result);
         end else begin
            e = sb.pop_front();
            chk("result", e.id, result, e.res);
            chk("remainder", e.id, remainder, e.rem);
            chk("overflow", e.id, {31'b0, overflow}, {31'b0, e.ov});
            chk("latency", e.id, cyc, e.done);
         end
      end
      ready_prev <= ready;
   end

   task automatic wait_idle();
      int n_wait = 0;
      @(negedge clk);
      while (ready !== 1'b1 && n_wait < 300) begin
         @(negedge clk);
         n_wait++;
      end
      if (ready !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: got ready=%b expected 1 within 300 cycles", ready);
      end
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] c, input logic [31:0] b,
                        input logic [31:0] er, input logic [31:0] erem, input logic eov,
                        input int id, input bit push);
      exp_t x;
      wait_idle();
      inA   = a;
      inC   = c;
      inB   = b;
      start = 1'b1;
      x.res  = er;
      x.rem  = erem;
      x.ov   = eov;
      x.id   = id;
      x.done = cyc + 1 + ((b == 32'h0) ? ZeroLat : Lat);
      if (push) sb.push_back(x);
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      rst_n = 1'b0;
      start = 1'b0;
      inA   = '0;
      inC   = '0;
      inB   = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 0, {31'b0, ready}, 32'd1);
      chk("reset_result", 0, result, 32'h0);
      chk("reset_remainder", 0, remainder, 32'h0);
      chk("reset_overflow", 0, {31'b0, overflow}, 32'h0);
      rst_n = 1'b1;

      issue(32'd13, 32'd143, 32'd12, 32'd13, 32'd0, 1'b0, 1, 1'b1);
      issue(32'd10, 32'hFFFFFFE1, 32'd4, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0, 2, 1'b1);
      issue(32'hFFFFFFF6, 32'd38, 32'hFFFFFFFE, 32'hFFFFFFF2, 32'd0, 1'b0, 3, 1'b1);
      issue(32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 4, 1'b1);
      issue(32'h80000000, 32'd0, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b1, 5, 1'b1);
      issue(32'h7FFFFFFF, 32'h7FFFFFFF, 32'd1, 32'hFFFFFFFE, 32'd0, 1'b1, 6, 1'b1);
      issue(32'h80000000, 32'h80000000, 32'd1, 32'h00000000, 32'd0, 1'b1, 7, 1'b1);
      issue(32'd7, 32'd0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 8, 1'b1);
      issue(32'hFFFFFFF9, 32'd0, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 9, 1'b1);
      issue(32'h80000000, 32'd0, 32'h80000000, 32'd1, 32'd0, 1'b0, 10, 1'b1);
      issue(32'h80000000, 32'd0, 32'd1, 32'h80000000, 32'd0, 1'b0, 11, 1'b1);

      // Second start while busy must be ignored.
      issue(32'd20, 32'd10, 32'd3, 32'd10, 32'd0, 1'b0, 12, 1'b1);
      repeat (9) @(negedge clk);
      inA   = 32'd1;
      inC   = 32'd1;
      inB   = 32'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;

      // Start held high: back-to-back operations every 35 cycles.
      wait_idle();
      inA   = 32'd100;
      inC   = 32'd0;
      inB   = 32'd7;
      start = 1'b1;
      base  = cyc;
      for (int i = 0; i < 3; i++) begin
         exp_t x;
         x.res  = 32'd14;
         x.rem  = 32'd2;
         x.ov   = 1'b0;
         x.id   = 20 + i;
         x.done = base + 1 + 35 * i + Lat;
         sb.push_back(x);
      end
      repeat (71) @(posedge clk);
      #1 start = 1'b0;

      // Reset in the middle of CALC aborts the operation.
      issue(32'd50, 32'd50, 32'd3, 32'd0, 32'd0, 1'b0, 30, 1'b0);
      repeat (14) @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_ready", 30, {31'b0, ready}, 32'd1);
      chk("abort_result", 30, result, 32'h0);
      chk("abort_remainder", 30, remainder, 32'h0);
      chk("abort_overflow", 30, {31'b0, overflow}, 32'h0);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("no_late_ready", 30, {31'b0, ready}, 32'd1);
      chk("no_late_result", 30, result, 32'h0);

      // Reset and start on the same edge: the request is dropped.
      rst_n = 1'b0;
      start = 1'b1;
      inA   = 32'd9;
      inC   = 32'd0;
      inB   = 32'd3;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b0;
      @(negedge clk);
      chk("reset_wins_ready", 31, {31'b0, ready}, 32'd1);

      issue(32'd1000, 32'hFFFFFC17, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 32, 1'b1);

      for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
      repeat (2) @(negedge clk);
      chk("scoreboard_empty", 0, sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
